// File: rtl/ahbl_arbiter2_if.sv
// AHB-Lite bus bundle shared by the arbiter's two master-facing ports and its downstream port.
// The master modport drives address/control/write data; the slave modport returns ready/read data.
interface ahbl_arbiter2_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahbl_arbiter2.sv
// Two-master AHB-Lite arbiter: shares one downstream bus between M0 and M1, buffering a
// losing master's address phase and stalling it through its own HREADY until the transfer issues.
module ahbl_arbiter2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahbl_arbiter2_if.slave  m0,
    ahbl_arbiter2_if.slave  m1,
    ahbl_arbiter2_if.master ds
);

    logic [1:0]        buf_v_q, buf_v_d;
    logic [1:0][31:0]  buf_addr_q, buf_addr_d;
    logic [1:0][2:0]   buf_size_q, buf_size_d;
    logic [1:0]        buf_write_q, buf_write_d;
    logic              rr_q, rr_d;
    logic              lock_q, lock_d;
    logic              lock_owner_q, lock_owner_d;
    logic              dp_v_q, dp_v_d;
    logic              dp_owner_q, dp_owner_d;

    logic [1:0][31:0]  live_addr_s;
    logic [1:0][2:0]   live_size_s;
    logic [1:0]        live_write_s;
    logic [1:0]        live_req_s;
    logic [1:0]        req_s;
    logic              sel_s;
    logic [31:0]       haddr_s;
    logic [2:0]        hsize_s;
    logic              hwrite_s;
    logic [1:0]        htrans_s;
    logic [1:0]        accept_s;
    logic [1:0]        mready_s;
    logic [1:0]        capture_s;

    assign live_addr_s[0]  = m0.HADDR;
    assign live_addr_s[1]  = m1.HADDR;
    assign live_size_s[0]  = m0.HSIZE;
    assign live_size_s[1]  = m1.HSIZE;
    assign live_write_s[0] = m0.HWRITE;
    assign live_write_s[1] = m1.HWRITE;
    assign live_req_s[0]   = m0.HTRANS[1];
    assign live_req_s[1]   = m1.HTRANS[1];

    // Grant selection; held on the locked owner while a downstream wait state is in progress.
    always_comb begin
        req_s = buf_v_q | live_req_s;
        if (lock_q) begin
            sel_s = lock_owner_q;
        end else if (req_s == 2'b11) begin
            sel_s = ROUND_ROBIN ? ~rr_q : 1'b0;
        end else if (req_s[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Downstream address phase: the buffered copy wins over the master's live inputs.
    always_comb begin
        if (buf_v_q[sel_s]) begin
            haddr_s  = buf_addr_q[sel_s];
            hsize_s  = buf_size_q[sel_s];
            hwrite_s = buf_write_q[sel_s];
        end else begin
            haddr_s  = live_addr_s[sel_s];
            hsize_s  = live_size_s[sel_s];
            hwrite_s = live_write_s[sel_s];
        end
        htrans_s = req_s[sel_s] ? 2'b10 : 2'b00;
    end

    // Per-master accept, stall and capture decisions.
    always_comb begin
        accept_s  = 2'b00;
        mready_s  = 2'b11;
        capture_s = 2'b00;
        for (int x = 0; x < 2; x++) begin
            accept_s[x] = (sel_s == x[0]) & req_s[x] & ds.HREADY;
            if (buf_v_q[x]) begin
                mready_s[x] = 1'b0;
            end else if (dp_v_q && (dp_owner_q == x[0])) begin
                mready_s[x] = ds.HREADY;
            end else begin
                mready_s[x] = 1'b1;
            end
            capture_s[x] = mready_s[x] & live_req_s[x] & ~accept_s[x];
        end
    end

    // Next-state for request buffers, round-robin pointer, lock and data-phase owner.
    always_comb begin
        buf_v_d      = buf_v_q;
        buf_addr_d   = buf_addr_q;
        buf_size_d   = buf_size_q;
        buf_write_d  = buf_write_q;
        rr_d         = rr_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        dp_v_d       = dp_v_q;
        dp_owner_d   = dp_owner_q;

        for (int x = 0; x < 2; x++) begin
            if (accept_s[x]) begin
                buf_v_d[x] = 1'b0;
            end else if (capture_s[x]) begin
                buf_v_d[x]     = 1'b1;
                buf_addr_d[x]  = live_addr_s[x];
                buf_size_d[x]  = live_size_s[x];
                buf_write_d[x] = live_write_s[x];
            end else begin
                buf_v_d[x] = buf_v_q[x];
            end
        end

        if (accept_s[0]) begin
            rr_d = 1'b0;
        end else if (accept_s[1]) begin
            rr_d = 1'b1;
        end else begin
            rr_d = rr_q;
        end

        // The lock freezes the address phase for as long as the downstream slave stalls.
        if (ds.HREADY) begin
            lock_d = 1'b0;
        end else if (htrans_s[1]) begin
            lock_d       = 1'b1;
            lock_owner_d = sel_s;
        end else begin
            lock_d = lock_q;
        end

        if (ds.HREADY) begin
            dp_v_d     = htrans_s[1];
            dp_owner_d = sel_s;
        end else begin
            dp_v_d     = dp_v_q;
            dp_owner_d = dp_owner_q;
        end
    end

    // State registers; rr resets to M1 so that M0 wins the first tie.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_v_q      <= 2'b00;
            buf_addr_q   <= '{default: 32'h0000_0000};
            buf_size_q   <= '{default: 3'b000};
            buf_write_q  <= 2'b00;
            rr_q         <= 1'b1;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            dp_v_q       <= 1'b0;
            dp_owner_q   <= 1'b0;
        end else begin
            buf_v_q      <= buf_v_d;
            buf_addr_q   <= buf_addr_d;
            buf_size_q   <= buf_size_d;
            buf_write_q  <= buf_write_d;
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            dp_v_q       <= dp_v_d;
            dp_owner_q   <= dp_owner_d;
        end
    end

    assign ds.HADDR  = haddr_s;
    assign ds.HTRANS = htrans_s;
    assign ds.HSIZE  = hsize_s;
    assign ds.HWRITE = hwrite_s;
    assign ds.HWDATA = dp_owner_q ? m1.HWDATA : m0.HWDATA;

    assign m0.HREADY = mready_s[0];
    assign m1.HREADY = mready_s[1];
    assign m0.HRDATA = ds.HRDATA;
    assign m1.HRDATA = ds.HRDATA;

endmodule

// File: doc/ahbl_arbiter2.md
Name: ahbl_arbiter2

Overview:
- Two-master AHB-Lite arbiter. It shares one downstream AHB-Lite bus (the splitter input) between master M0 (the CPU) and master M1 (a future DMA/accelerator port).
- Each master sees a private AHB-Lite slave port. A master that is not granted is stalled through its own HREADY; its pending address is captured in a per-master request buffer so that its previous data phase still completes cleanly.
- Arbitration is round-robin (or fixed M0 priority). The grant switches only at transfer boundaries and never during a downstream wait state.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate the grant on simultaneous requests; 0 = M0 always wins.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- M0_HADDR, M1_HADDR  in  32  master address.
- M0_HTRANS, M1_HTRANS  in  2  master transfer type; bit 1 = request.
- M0_HSIZE, M1_HSIZE  in  3  master transfer size.
- M0_HWRITE, M1_HWRITE  in  1  master write flag.
- M0_HWDATA, M1_HWDATA  in  32  master write data (data phase).
- M0_HREADY, M1_HREADY  out  1  per-master ready / stall.
- M0_HRDATA, M1_HRDATA  out  32  read data; both are a copy of HRDATA.
- HADDR  out  32  downstream address.
- HTRANS  out  2  downstream transfer type.
- HSIZE  out  3  downstream size.
- HWRITE  out  1  downstream write flag.
- HWDATA  out  32  downstream write data.
- HREADY  in  1  downstream ready (from splitter).
- HRDATA  in  32  downstream read data.

Behaviour:
- State registers:
  - buf_v[x] plus buf_addr/size/write[x], per master.
  - rr: last granted master.
  - lock, lock_owner.
  - dp_v, dp_owner: downstream data-phase owner.
- Reset values: buf_v=0, rr=1 (M0 wins the first tie), lock=0, dp_v=0, dp_owner=0. The outputs therefore come out of reset as HTRANS=IDLE, HADDR/HSIZE/HWRITE taken from M0 live inputs, M0_HREADY=M1_HREADY=1.
- Request per master: req_x = buf_v[x] OR Mx_HTRANS[1]. The buffered copy takes precedence over the live inputs.
- Grant (sel, combinational):
  - If lock=1: sel=lock_owner.
  - Else if both request: sel = ROUND_ROBIN ? ~rr : 0.
  - Else sel = the requesting master.
  - If neither requests: sel=0.
  - sel never depends combinationally on HREADY.
- Downstream address outputs:
  - HADDR/HSIZE/HWRITE are taken from buf[sel] when buf_v[sel]=1, otherwise from M<sel> live inputs.
  - HTRANS=2'b10 (NONSEQ) when req_sel=1, otherwise 2'b00. SEQ is never forwarded.
- Lock:
  - At a clock edge with HTRANS[1]=1 and HREADY=0: lock<=1, lock_owner<=sel.
  - At a clock edge with HREADY=1: lock<=0.
  - Effect: the address held during wait states never changes.
- Accept: accept_x = (sel==x) & req_x & HREADY. On accept_x:
  - rr<=x.
  - buf_v[x]<=0 if it was set.
- Data phase: on every edge with HREADY=1, dp_v<=HTRANS[1] and dp_owner<=sel. HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA.
- Master ready, Mx_HREADY:
  - 0 if buf_v[x]=1.
  - Else HREADY if dp_v & dp_owner==x.
  - Else 1.
- Capture: at an edge where Mx_HREADY=1, Mx_HTRANS[1]=1 and !accept_x, then buf_v[x]<=1 and the buffer latches the master's HADDR/HSIZE/HWRITE. The master then believes its address was accepted and stalls in its next data phase until the buffered transfer issues and completes.
- Latency:
  - Uncontended transfer: zero added cycles; address and data pass straight through.
  - Contended transfer: the loser waits one extra downstream transfer per competing grant.
- Simultaneous events:
  - Capture and accept of the same master in one cycle cannot occur; they are mutually exclusive by definition.
  - The other master may capture during any downstream wait state.
- Reset mid-transfer: all state clears asynchronously. Any buffered request is dropped, and the masters are reset by the same HRESETn.
- Starvation: round-robin bounds the wait to one transfer of the other master.

Test Plan:
- Only M0 issues a read of 0x0000_0010 (slave HREADY=1 always) -> HADDR=0x10 in the same cycle, M0_HREADY=1 throughout, M0_HRDATA=HRDATA next cycle, M1_HREADY=1.
- M0 and M1 both issue NONSEQ in the first cycle after reset, to 0x2000_0000 and 0x4000_0000 -> M0 is granted first; M1 is captured (buf_v[1]=1, M1_HREADY=0); the next cycle HADDR=0x4000_0000; M1_HREADY returns to 1 when its data phase completes.
- Both masters request continuously for 8 cycles with ROUND_ROBIN=1 -> HADDR alternates M0/M1 every accepted transfer, 4 grants each. With ROUND_ROBIN=0 -> M1 gets no grants while M0 keeps requesting.
- M0 write 0xDEADBEEF to 0x2000_0004; slave holds HREADY=0 for 3 cycles; M1 requests in wait cycle 2 -> HADDR/HTRANS stay on the M0 transfer (lock), HWDATA=0xDEADBEEF stable, M1 is buffered and issued after HREADY rises.
- M1 write 0x12345678 is buffered while M0 owns the data phase -> after issue, HWDATA switches to M1_HWDATA=0x12345678 in M1's data phase; M0 sees no stall beyond its own transfer.
- Assert HRESETn=0 while buf_v[1]=1 and lock=1 -> in the same cycle HTRANS=IDLE (no live requests), both Mx_HREADY=1, and nothing is issued after release.
